// File: rtl/input_fifo_wconv_pkg.sv
// Shared helpers for the width-converting input FIFO.
package input_fifo_wconv_pkg;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Input word width: RATIO output sub-words packed side by side.
  function automatic int in_width(input int out_width, input int ratio);
    return out_width * ratio;
  endfunction

  // Width of the sub-word index; at least one bit even when RATIO == 1.
  function automatic int sel_width(input int ratio);
    return (ratio > 1) ? clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/input_fifo_wconv_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// read-enabled output. The output register doubles as the FIFO prefetch stage.
module fifo_sync_ram #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: output holds its value until the next issued read.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/input_fifo_wconv.sv
// First-word fall-through FIFO that splits each IN_WIDTH input word into
// RATIO output words. Storage path: RAM -> prefetch (RAM output register)
// -> hold register with sub-word index.
//
// Handshake: the write side is accepted on wr_en & ~full (wr_en while full is
// dropped); the read side presents dout whenever ~empty and a word is consumed
// on rd_en & ~empty (rd_en while empty is ignored).
module input_fifo_wconv
  import input_fifo_wconv_pkg::*;
#(
  parameter int OUT_WIDTH        = 8,
  parameter int RATIO            = 2,
  parameter int DEPTH_LOG2       = 10,
  parameter int PROG_FULL_THRESH = 512,
  parameter bit MSB_FIRST        = 1'b0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [in_width(OUT_WIDTH, RATIO)-1:0]   din,
  input  logic                                    wr_en,
  output logic                                    full,
  output logic                                    almost_full,
  output logic                                    prog_full,
  output logic [DEPTH_LOG2:0]                     data_count,
  input  logic                                    rd_en,
  output logic [OUT_WIDTH-1:0]                    dout,
  output logic                                    empty
);

  localparam int IN_WIDTH = in_width(OUT_WIDTH, RATIO);
  localparam int DEPTH    = 2 ** DEPTH_LOG2;
  localparam int SEL_W    = sel_width(RATIO);
  localparam int CNT_W    = DEPTH_LOG2 + 1;

  if (RATIO < 1) begin : g_bad_ratio
    $error("input_fifo_wconv: RATIO must be >= 1");
  end
  if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH) begin : g_bad_thresh
    $error("input_fifo_wconv: PROG_FULL_THRESH must be within 1..DEPTH");
  end

  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [CNT_W-1:0]      count, count_next;
  logic                  pf_valid, hold_valid;
  logic [IN_WIDTH-1:0]   hold, ram_q;
  logic [SEL_W-1:0]      sel, sel_idx;
  logic                  wr_accept, pop, last_pop, pf_load, rd_issue;

  // Control decode for write acceptance, pop, prefetch load and RAM read.
  always_comb begin
    wr_accept  = wr_en & ~full;
    pop        = rd_en & hold_valid;
    last_pop   = pop & (sel == SEL_W'(RATIO - 1));
    pf_load    = pf_valid & (~hold_valid | last_pop);
    // count > 0 keeps rptr off the location being written this cycle.
    rd_issue   = (count != '0) & (~pf_valid | pf_load);
    count_next = count + CNT_W'(wr_accept) - CNT_W'(rd_issue);
  end

  fifo_sync_ram #(
    .WIDTH  (IN_WIDTH),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept & ~rst),
    .wr_addr (wptr),
    .wr_data (din),
    .rd_en   (rd_issue & ~rst),
    .rd_addr (rptr),
    .rd_data (ram_q)
  );

  // Pointers, RAM count and registered flags taken from the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      prog_full   <= 1'b0;
    end else begin
      if (wr_accept) wptr <= wptr + DEPTH_LOG2'(1);
      if (rd_issue)  rptr <= rptr + DEPTH_LOG2'(1);
      count       <= count_next;
      full        <= (count_next == CNT_W'(DEPTH));
      almost_full <= (count_next >= CNT_W'(DEPTH - 1));
      prog_full   <= (count_next >= CNT_W'(PROG_FULL_THRESH));
    end
  end

  // Prefetch valid, hold register and sub-word index.
  always_ff @(posedge clk) begin
    if (rst) begin
      pf_valid   <= 1'b0;
      hold_valid <= 1'b0;
      hold       <= '0;
      sel        <= '0;
    end else begin
      if (rd_issue)     pf_valid <= 1'b1;
      else if (pf_load) pf_valid <= 1'b0;

      if (pf_load) begin
        hold       <= ram_q;
        hold_valid <= 1'b1;
      end else if (last_pop) begin
        hold_valid <= 1'b0;
      end

      if (pop) sel <= last_pop ? '0 : sel + SEL_W'(1);
    end
  end

  // Output sub-word select; index reversed for top-first ordering.
  always_comb begin
    sel_idx = MSB_FIRST ? (SEL_W'(RATIO - 1) - sel) : sel;
    dout    = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (sel_idx == SEL_W'(i)) dout = hold[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign empty      = ~hold_valid;
  assign data_count = count;

endmodule

// File: tb/tb_input_fifo_wconv.sv
// Directed bench for input_fifo_wconv: three instances cover the default
// 16->8 configuration, a 32->8 top-first configuration and a RATIO=1 FIFO.
module tb_input_fifo_wconv;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT a: defaults ----------------
  logic [15:0] a_din;
  logic        a_wr, a_rd, a_full, a_af, a_pf, a_empty;
  logic [10:0] a_dc;
  logic [7:0]  a_dout;

  input_fifo_wconv u_a (
    .clk(clk), .rst(rst), .din(a_din), .wr_en(a_wr), .full(a_full),
    .almost_full(a_af), .prog_full(a_pf), .data_count(a_dc),
    .rd_en(a_rd), .dout(a_dout), .empty(a_empty)
  );

  // ---------------- DUT b: RATIO=4, top sub-word first ----------------
  logic [31:0] b_din;
  logic        b_wr, b_rd, b_full, b_af, b_pf, b_empty;
  logic [4:0]  b_dc;
  logic [7:0]  b_dout;

  input_fifo_wconv #(
    .OUT_WIDTH(8), .RATIO(4), .DEPTH_LOG2(4), .PROG_FULL_THRESH(8), .MSB_FIRST(1'b1)
  ) u_b (
    .clk(clk), .rst(rst), .din(b_din), .wr_en(b_wr), .full(b_full),
    .almost_full(b_af), .prog_full(b_pf), .data_count(b_dc),
    .rd_en(b_rd), .dout(b_dout), .empty(b_empty)
  );

  // ---------------- DUT c: RATIO=1, depth 8 ----------------
  logic [7:0]  c_din;
  logic        c_wr, c_rd, c_full, c_af, c_pf, c_empty;
  logic [3:0]  c_dc;
  logic [7:0]  c_dout;

  input_fifo_wconv #(
    .OUT_WIDTH(8), .RATIO(1), .DEPTH_LOG2(3), .PROG_FULL_THRESH(4), .MSB_FIRST(1'b0)
  ) u_c (
    .clk(clk), .rst(rst), .din(c_din), .wr_en(c_wr), .full(c_full),
    .almost_full(c_af), .prog_full(c_pf), .data_count(c_dc),
    .rd_en(c_rd), .dout(c_dout), .empty(c_empty)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;
  int a_seq        = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Back-to-back writes into DUT a; bytes go to the scoreboard low first.
  task automatic write_a(input int n, input bit track);
    for (int i = 0; i < n; i++) begin
      a_din = a_seq[15:0];
      a_wr  = 1'b1;
      if (track) begin
        exp_q.push_back(a_seq[7:0]);
        exp_q.push_back(a_seq[15:8]);
      end
      a_seq++;
      tick();
    end
    a_wr = 1'b0;
  endtask

  // Pop DUT a until the scoreboard is empty, requiring a word every cycle.
  task automatic drain_a(input string tag);
    logic [7:0] e;
    a_rd = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_empty"}, a_empty, 1'b0);
      check({tag, "_dout"}, a_dout, e);
      tick();
    end
    a_rd = 1'b0;
    check({tag, "_empty_after"}, a_empty, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] e;
    int guard;
    rst = 1'b1;
    a_din = '0; a_wr = 1'b0; a_rd = 1'b0;
    b_din = '0; b_wr = 1'b0; b_rd = 1'b0;
    c_din = '0; c_wr = 1'b0; c_rd = 1'b0;
    idle(2);
    rst = 1'b0;
    tick();

    // Reset state of every instance.
    check("a_rst_empty", a_empty, 1'b1);
    check("a_rst_full", a_full, 1'b0);
    check("a_rst_af", a_af, 1'b0);
    check("a_rst_pf", a_pf, 1'b0);
    check("a_rst_dc", a_dc, 11'd0);
    check("a_rst_dout", a_dout, 8'h00);
    check("b_rst_empty", b_empty, 1'b1);
    check("b_rst_dout", b_dout, 8'h00);
    check("c_rst_empty", c_empty, 1'b1);
    check("c_rst_dc", c_dc, 4'd0);

    // Single word 16'hA1B2, rd_en held high: visible in cycle 3, low byte first.
    a_din = 16'hA1B2; a_wr = 1'b1; a_rd = 1'b1;
    tick();                                   // cycle 1
    a_wr = 1'b0;
    check("t1_c1_empty", a_empty, 1'b1);
    tick();                                   // cycle 2
    check("t1_c2_empty", a_empty, 1'b1);
    tick();                                   // cycle 3
    check("t1_c3_empty", a_empty, 1'b0);
    check("t1_c3_dout", a_dout, 8'hB2);
    tick();                                   // cycle 4
    check("t1_c4_empty", a_empty, 1'b0);
    check("t1_c4_dout", a_dout, 8'hA1);
    tick();                                   // cycle 5
    check("t1_c5_empty", a_empty, 1'b1);
    a_rd = 1'b0;

    // Fill: two words settle into prefetch/hold, then the RAM count climbs.
    write_a(2, 1'b1);
    idle(4);
    check("t2_pipe_dc", a_dc, 11'd0);
    check("t2_pipe_empty", a_empty, 1'b0);
    write_a(511, 1'b1);
    idle(3);
    check("t2_511_dc", a_dc, 11'd511);
    check("t2_511_pf", a_pf, 1'b0);
    write_a(1, 1'b1);
    idle(3);
    check("t2_512_dc", a_dc, 11'd512);
    check("t2_512_pf", a_pf, 1'b1);
    check("t2_512_af", a_af, 1'b0);
    write_a(511, 1'b1);
    idle(3);
    check("t2_1023_dc", a_dc, 11'd1023);
    check("t2_1023_af", a_af, 1'b1);
    check("t2_1023_full", a_full, 1'b0);
    write_a(1, 1'b1);
    idle(3);
    check("t2_1024_dc", a_dc, 11'd1024);
    check("t2_1024_full", a_full, 1'b1);
    a_din = 16'hDEAD; a_wr = 1'b1;            // dropped: FIFO is full
    tick();
    a_wr = 1'b0;
    idle(2);
    check("t2_drop_dc", a_dc, 11'd1024);
    check("t2_drop_full", a_full, 1'b1);
    drain_a("t2_drain");
    check("t2_end_dc", a_dc, 11'd0);
    check("t2_end_full", a_full, 1'b0);

    // Steady state at count 100; reads of the RAM occur on every second pop,
    // writes are placed on those same cycles so the count never moves.
    write_a(102, 1'b1);
    idle(4);
    check("t3_start_dc", a_dc, 11'd100);
    a_rd = 1'b1;
    for (int c = 0; c < 200; c++) begin
      a_wr = c[0];
      if (a_wr) begin
        a_din = a_seq[15:0];
        exp_q.push_back(a_seq[7:0]);
        exp_q.push_back(a_seq[15:8]);
        a_seq++;
      end
      e = exp_q.pop_front();
      check("t3_empty", a_empty, 1'b0);
      check("t3_dout", a_dout, e);
      check("t3_dc", a_dc, 11'd100);
      tick();
    end
    a_wr = 1'b0;
    drain_a("t3_drain");

    // RATIO=4, top sub-word first, two back-to-back words.
    b_din = 32'h11223344; b_wr = 1'b1; b_rd = 1'b1;
    tick();                                   // cycle 1
    b_din = 32'hAABBCCDD;
    tick();                                   // cycle 2
    b_wr = 1'b0;
    check("t4_c2_empty", b_empty, 1'b1);
    tick();                                   // cycle 3
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC); exp_q.push_back(8'hDD);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("t4_empty", b_empty, 1'b0);
      check("t4_dout", b_dout, e);
      tick();
    end
    b_rd = 1'b0;
    check("t4_empty_after", b_empty, 1'b0 ^ 1'b1);

    // RATIO=1 directed fill: capacity 8 + 2, writes 10 and 11 are dropped.
    c_wr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      c_din = 8'(8'h40 + i);
      if (i < 10) exp_q.push_back(8'(8'h40 + i));
      tick();
    end
    c_wr = 1'b0;
    check("t5_fill_dc", c_dc, 4'd8);
    check("t5_fill_full", c_full, 1'b1);
    check("t5_fill_af", c_af, 1'b1);
    check("t5_fill_pf", c_pf, 1'b1);
    c_rd = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("t5_fill_empty", c_empty, 1'b0);
      check("t5_fill_dout", c_dout, e);
      tick();
    end
    idle(2);                                  // rd_en while empty
    check("t5_idle_empty", c_empty, 1'b1);
    check("t5_idle_dc", c_dc, 4'd0);

    // RATIO=1 random traffic at 50% duty on both sides.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      c_wr  = 1'($urandom_range(0, 1));
      c_rd  = 1'($urandom_range(0, 1));
      c_din = 8'($urandom_range(0, 255));
      if (c_wr && !c_full) exp_q.push_back(c_din);
      if (c_rd && !c_empty) begin
        e = exp_q.pop_front();
        check("t5_rand_dout", c_dout, e);
      end
      check("t5_rand_full", c_full, (c_dc == 4'd8));
      check("t5_rand_pf", c_pf, (c_dc >= 4'd4));
      tick();
    end
    c_wr = 1'b0;
    c_rd = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      if (!c_empty) begin
        e = exp_q.pop_front();
        check("t5_drain_dout", c_dout, e);
      end
      guard++;
      tick();
    end
    check("t5_drain_left", exp_q.size(), 0);
    check("t5_drain_empty", c_empty, 1'b1);
    c_rd = 1'b0;

    // Reset with ~300 words queued and the hold register half consumed.
    write_a(302, 1'b0);
    idle(3);
    a_rd = 1'b1;
    tick();
    rst = 1'b1; a_wr = 1'b1; a_rd = 1'b1; a_din = 16'h5555;
    tick();
    rst = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
    check("t6_empty", a_empty, 1'b1);
    check("t6_full", a_full, 1'b0);
    check("t6_af", a_af, 1'b0);
    check("t6_pf", a_pf, 1'b0);
    check("t6_dc", a_dc, 11'd0);
    check("t6_dout", a_dout, 8'h00);
    a_din = 16'h7788; a_wr = 1'b1;            // cycle 0
    tick();
    a_wr = 1'b0;
    tick();
    check("t6_c2_empty", a_empty, 1'b1);
    tick();
    check("t6_c3_empty", a_empty, 1'b0);
    check("t6_c3_dout", a_dout, 8'h88);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
